pwm_capture: RTL and testbench

- Measures an incoming PWM waveform: period and high time, in clk50m cycles.
- This is the receive-side counterpart of the team's PWM counter/generator. Typical uses are loopback checking of generated PWM and capturing external PWM inputs.
- It publishes a new {period, high-time} pair once per input period with a one-cycle valid strobe.
- It flags a stuck input (0 %/100 % duty) via a timeout.

---
 rtl/pwm_pkg.sv | 8 +
 rtl/pwm_edge_det.sv | 67 ++++++
 rtl/pwm_capture.sv | 127 ++++++++++++
 tb/tb_pwm_capture.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM capture block.
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} pwm_cap_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_edge_det.sv
// PWM input conditioning: synchronizer, optional glitch filter (PWM_CAP_FILT_EN),
// level output and single-cycle rise/fall pulses.
module pwm_edge_det
    import pwm_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic i_pwm,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_range
        $error("pwm_edge_det: FILT_LEN must be within 2..15");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_lvl;
    logic                   r_lvl_d;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_CAP_FILT_EN
    logic       r_filt;
    logic [3:0] r_fcnt;

    // Level flips only after FILT_LEN consecutive disagreeing samples.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (w_sync != r_filt) begin
            if (r_fcnt == 4'(FILT_LEN - 1)) begin
                r_filt <= w_sync;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 4'd1;
            end
        end else begin
            r_fcnt <= '0;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = w_sync;
`endif

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) r_lvl_d <= 1'b0;
        else        r_lvl_d <= w_lvl;
    end

    assign o_lvl  = w_lvl;
    assign o_rise = w_lvl & ~r_lvl_d;
    assign o_fall = ~w_lvl & r_lvl_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-input timeout.
// Optional input glitch filter enabled by defining PWM_CAP_FILT_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int W        = 16,
    parameter int FILT_LEN = 4
) (
    input  logic         rst_n,
    input  logic         clk50m,
    input  logic         en,
    input  logic         pwm_in,
    output logic [W-1:0] per_meas,
    output logic [W-1:0] hi_meas,
    output logic         valid,
    output logic         tmo,
    output logic         lvl
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic w_rise, w_fall, w_lvl;

    pwm_edge_det #(.FILT_LEN(FILT_LEN)) u_edge (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .i_pwm  (pwm_in),
        .o_lvl  (w_lvl),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    pwm_cap_state_t r_state, w_state_nx;
    logic [W-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
    logic [W-1:0]   r_hi_q, w_hi_q_nx;
    logic [W-1:0]   r_per, w_per_nx;
    logic [W-1:0]   r_hi, w_hi_nx;
    logic           r_valid, w_valid_nx;
    logic           r_tmo, w_tmo_nx;

    // Saturating: only reachable at max after a fall lands on the last count.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_q_nx  = r_hi_q;
        w_per_nx   = r_per;
        w_hi_nx    = r_hi;
        w_valid_nx = 1'b0;
        w_tmo_nx   = r_tmo;
        if (!en) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nx = WAIT_RISE;
                    w_cnt_nx   = '0;
                end
                WAIT_RISE: begin
                    if (w_rise) begin
                        w_cnt_nx   = W'(1);
                        w_state_nx = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (w_fall) begin
                        w_hi_q_nx  = r_cnt;
                        w_cnt_nx   = w_cnt_inc;
                        w_state_nx = MEAS_LOW;
                    end else if (r_cnt == CNT_MAX) begin
                        w_tmo_nx   = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = WAIT_RISE;
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                    end
                end
                MEAS_LOW: begin
                    if (w_rise) begin
                        w_per_nx   = r_cnt;
                        w_hi_nx    = r_hi_q;
                        w_valid_nx = 1'b1;
                        w_tmo_nx   = 1'b0;
                        w_cnt_nx   = W'(1);
                        w_state_nx = MEAS_HIGH;
                    end else if (r_cnt == CNT_MAX) begin
                        w_tmo_nx   = 1'b1;
                        w_cnt_nx   = '0;
                        w_state_nx = WAIT_RISE;
                    end else begin
                        w_cnt_nx   = w_cnt_inc;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hi_q  <= '0;
            r_per   <= '0;
            r_hi    <= '0;
            r_valid <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi_q  <= w_hi_q_nx;
            r_per   <= w_per_nx;
            r_hi    <= w_hi_nx;
            r_valid <= w_valid_nx;
            r_tmo   <= w_tmo_nx;
        end
    end

    assign per_meas = r_per;
    assign hi_meas  = r_hi;
    assign valid    = r_valid;
    assign tmo      = r_tmo;
    assign lvl      = w_lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (W=8): per-cycle comparison against an edge-timestamp model,
// plus literal expectations for the directed scenarios.
module tb_pwm_capture;

    localparam int W   = 8;
    localparam int FL  = 4;
    localparam int MAX = (1 << W) - 1;

    logic         rst_n  = 1'b1;
    logic         clk50m = 1'b0;
    logic         en     = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] per_meas, hi_meas;
    logic         valid, tmo, lvl;

    pwm_capture #(.W(W), .FILT_LEN(FL)) dut (
        .rst_n    (rst_n),
        .clk50m   (clk50m),
        .en       (en),
        .pwm_in   (pwm_in),
        .per_meas (per_meas),
        .hi_meas  (hi_meas),
        .valid    (valid),
        .tmo      (tmo),
        .lvl      (lvl)
    );

    always #10 clk50m = ~clk50m;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_odd = 0;
    bit count_odd = 0;
    int g = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " per_meas"}, per_meas, 0);
        chk({tag, " hi_meas"},  hi_meas,  0);
        chk({tag, " valid"},    valid,    0);
        chk({tag, " tmo"},      tmo,      0);
        chk({tag, " lvl"},      lvl,      0);
    endtask

    // Model: the pin sampled at step N becomes the level one step later
    // (or the filtered version of it); an edge acts on the FSM one step after the level moves.
    int step = 0;
    bit p_prev, p_prev2, lvl_m1, lvl_m2, m_filt;
    bit win[FL];
    bit m_act, m_armed, m_fallen;
    int t0, m_hiq, e_per, e_hi;
    bit e_valid, e_tmo;

    always begin
        bit lvl_now, rise, fall, all_diff;
        int el;
        @(posedge clk50m);
        #1;
        step++;
        if (!rst_n) begin
            p_prev = 0; p_prev2 = 0; lvl_m1 = 0; lvl_m2 = 0; m_filt = 0;
            for (int i = 0; i < FL; i++) win[i] = 0;
            m_act = 0; m_armed = 0; m_fallen = 0;
            e_per = 0; e_hi = 0; e_valid = 0; e_tmo = 0;
            lvl_now = 0;
        end else begin
`ifdef PWM_CAP_FILT_EN
            for (int i = FL - 1; i > 0; i--) win[i] = win[i-1];
            win[0] = p_prev2;
            all_diff = 1;
            for (int i = 0; i < FL; i++) if (win[i] == m_filt) all_diff = 0;
            if (all_diff) m_filt = !m_filt;
            lvl_now = m_filt;
`else
            all_diff = 0;
            lvl_now = p_prev;
`endif
            p_prev2 = p_prev;
            p_prev  = pwm_in;
            rise = lvl_m1 && !lvl_m2;
            fall = !lvl_m1 && lvl_m2;
            e_valid = 0;
            if (!en) begin
                m_act = 0; m_armed = 0;
            end else if (!m_act) begin
                m_act = 1;
            end else if (!m_armed) begin
                if (rise) begin m_armed = 1; m_fallen = 0; t0 = step; end
            end else begin
                el = step - t0;
                if (el > MAX) el = MAX;
                if (!m_fallen) begin
                    if (fall) begin m_hiq = el; m_fallen = 1; end
                    else if (el == MAX) begin e_tmo = 1; m_armed = 0; end
                end else begin
                    if (rise) begin
                        e_valid = 1; e_per = el; e_hi = m_hiq; e_tmo = 0;
                        t0 = step; m_fallen = 0;
                    end else if (el == MAX) begin
                        e_tmo = 1; m_armed = 0;
                    end
                end
            end
            lvl_m2 = lvl_m1;
            lvl_m1 = lvl_now;
        end
        chk("model valid",    valid,    e_valid);
        chk("model per_meas", per_meas, e_per);
        chk("model hi_meas",  hi_meas,  e_hi);
        chk("model tmo",      tmo,      e_tmo);
        chk("model lvl",      lvl,      lvl_now);
        if (valid) n_valid++;
        if (count_odd && valid && per_meas != 8'd20) n_odd++;
    end

    // Up-counting generator: high while count < cmp, count wraps after per.
    task automatic gen(input int per, input int cmp, input int n);
        repeat (n) begin
            @(negedge clk50m);
            pwm_in = (g < cmp);
            g = (g >= per) ? 0 : g + 1;
        end
    endtask

    task automatic hold(input bit v, input int n);
        repeat (n) begin
            @(negedge clk50m);
            pwm_in = v;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk50m);
        rst_n = 1'b1;
        en    = 1'b1;

        // Nominal 10-cycle period, 3 high.
        n_valid = 0;
        g = 0;
        gen(9, 3, 65);
`ifndef PWM_CAP_FILT_EN
        chk("p10 valids", n_valid, 6);
        chk("p10 per", per_meas, 10);
        chk("p10 hi", hi_meas, 3);
        chk("p10 tmo", tmo, 0);
`endif

        // Mid-stream switch to period 5, 2 high.
        g = 0;
        gen(4, 2, 40);
`ifndef PWM_CAP_FILT_EN
        chk("p5 per", per_meas, 5);
        chk("p5 hi", hi_meas, 2);
        chk("p5 tmo", tmo, 0);
`endif

        // Stuck high -> timeout.
        g = 0;
        gen(4, 2, 5);
        hold(1'b1, 10);
        n_valid = 0;
        hold(1'b1, 300);
        chk("stuck tmo", tmo, 1);
        chk("stuck lvl", lvl, 1);
        chk("stuck valids", n_valid, 0);
        hold(1'b0, 20);
        g = 0;
        gen(9, 3, 25);
`ifndef PWM_CAP_FILT_EN
        chk("recover tmo", tmo, 0);
        chk("recover per", per_meas, 10);
`endif

        // Disable during low phase.
        gen(9, 3, 3);
        en = 1'b0;
        n_valid = 0;
        gen(9, 3, 30);
        chk("disabled valids", n_valid, 0);
`ifndef PWM_CAP_FILT_EN
        chk("disabled per hold", per_meas, 10);
        chk("disabled hi hold", hi_meas, 3);
`endif
        @(negedge clk50m);
        en = 1'b1;
        gen(9, 3, 40);

        // Asynchronous reset in the middle of a high phase.
        g = 0;
        gen(9, 3, 5);
        #3 rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk50m);
        rst_n = 1'b1;
        g = 0;
        gen(9, 3, 40);

        // Period 20 / high 5 with a 2-cycle glitch inside one low phase.
        for (int k = 0; k < 6; k++) begin
            if (k == 1) begin n_odd = 0; count_odd = 1; end
            for (int j = 0; j < 20; j++) begin
                @(negedge clk50m);
                pwm_in = (j < 5) || (k == 3 && (j == 10 || j == 11));
            end
        end
        hold(1'b1, 5);
        count_odd = 0;
`ifdef PWM_CAP_FILT_EN
        chk("glitch odd valids", n_odd, 0);
`else
        chk("glitch odd valids", n_odd, 2);
`endif
        chk("glitch per", per_meas, 20);
        chk("glitch hi", hi_meas, 5);

        repeat (3) @(negedge clk50m);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
